// File: rtl/i2s_rx.sv
// I2S receiver: oversamples the serial bus on clk_74a, locks to word select
// and delivers left/right sample pairs with a one-cycle strobe.
module i2s_rx #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk_74a,
    input  logic                  reset_n,
    input  logic                  audio_sclk,
    input  logic                  audio_lrck,
    input  logic                  audio_adc,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  word_drop
);

    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SKIP     = 2'd1,
        SHIFT    = 2'd2
    } state_t;

    // Bit order in the synchronizer vectors: {sclk, lrck, adc}
    logic [2:0]            sync_q1;
    logic [2:0]            sync_q2;
    logic [2:0]            sync_q3;

    state_t                state;
    state_t                state_d;

    logic                  prev_lrck;
    logic                  have_prev;
    logic                  chan;
    logic                  left_ok;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] hold;

    logic                  bit_evt_c;
    logic                  lrck_c;
    logic                  adc_c;
    logic                  lrck_chg_c;
    logic [DATA_WIDTH-1:0] word_c;
    logic                  start_c;
    logic                  shift_c;
    logic                  done_c;
    logic                  partial_c;

    // Two-flop synchronizers plus one delay stage; lrck/adc stay aligned with the delayed sclk
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            sync_q3 <= '0;
        end else begin
            sync_q1 <= {audio_sclk, audio_lrck, audio_adc};
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign bit_evt_c  = sync_q2[2] & ~sync_q3[2];
    assign lrck_c     = sync_q3[1];
    assign adc_c      = sync_q3[0];
    // The first sampled lrck after reset only seeds the history; it is never a transition
    assign lrck_chg_c = bit_evt_c & have_prev & (lrck_c != prev_lrck);
    assign word_c     = {shreg[DATA_WIDTH-2:0], adc_c};

    // State register
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d   = state;
        start_c   = 1'b0;
        shift_c   = 1'b0;
        done_c    = 1'b0;
        partial_c = 1'b0;
        case (state)
            UNLOCKED: begin
                if (lrck_chg_c) begin
                    state_d = SKIP;
                end
            end
            SKIP: begin
                if (lrck_chg_c) begin
                    state_d = SHIFT;
                    start_c = 1'b1;
                end
            end
            SHIFT: begin
                if (lrck_chg_c) begin
                    start_c   = 1'b1;
                    partial_c = (bit_cnt != '0) && (bit_cnt < CNT_FULL);
                end else if (bit_evt_c && (bit_cnt < CNT_FULL)) begin
                    shift_c = 1'b1;
                    done_c  = (bit_cnt == CNT_LAST);
                end
            end
            default: begin
                state_d = UNLOCKED;
            end
        endcase
    end

    // Shifter, channel tracking, left holding register and output pair
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            prev_lrck    <= 1'b0;
            have_prev    <= 1'b0;
            chan         <= 1'b0;
            left_ok      <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            hold         <= '0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            word_drop    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            word_drop    <= 1'b0;
            if (bit_evt_c) begin
                prev_lrck <= lrck_c;
                have_prev <= 1'b1;
            end
            // The adc bit on a transition event is the previous slot's trailing bit
            if (start_c) begin
                chan      <= lrck_c;
                bit_cnt   <= '0;
                shreg     <= '0;
                word_drop <= partial_c;
                if (!lrck_c) begin
                    left_ok <= 1'b0;
                end
            end
            if (shift_c) begin
                shreg   <= word_c;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (done_c) begin
                if (!chan) begin
                    hold    <= word_c;
                    left_ok <= 1'b1;
                end else if (left_ok) begin
                    left_sample  <= hold;
                    right_sample <= word_c;
                    sample_valid <= 1'b1;
                end else begin
                    word_drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: slot-level reference model feeding a scoreboard queue,
// with a monitor that checks every strobe, its payload and its latency.
module tb_i2s_rx;

    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          clk_74a      = 1'b0;
    logic          reset_n      = 1'b0;
    logic          audio_sclk   = 1'b0;
    logic          audio_lrck   = 1'b0;
    logic          audio_adc    = 1'b0;
    logic [DW-1:0] left_sample;
    logic [DW-1:0] right_sample;
    logic          sample_valid;
    logic          word_drop;

    i2s_rx #(.DATA_WIDTH(DW)) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .audio_sclk   (audio_sclk),
        .audio_lrck   (audio_lrck),
        .audio_adc    (audio_adc),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .word_drop    (word_drop)
    );

    always #5 clk_74a = ~clk_74a;

    int cyc = 0;
    always @(posedge clk_74a) cyc <= cyc + 1;

    typedef struct {
        bit            is_valid;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            edge_idx;
    } exp_t;

    exp_t exp_q[$];
    int   rise_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0;

    // Reference model state, tracked per whole slot
    bit            m_known   = 1'b0;
    bit            m_prev    = 1'b0;
    int            m_phase   = 0;     // 0 unlocked, 1 skipping lock slot, 2 capturing
    bit            m_pend    = 1'b0;  // current slot will end as a partial word
    bit            m_left_ok = 1'b0;
    logic [DW-1:0] m_hold    = '0;

    exp_t mon_e;

    task automatic push_exp(input bit v, input logic [DW-1:0] l, input logic [DW-1:0] r, input int idx);
        exp_t e;
        e.is_valid = v;
        e.l        = l;
        e.r        = r;
        e.edge_idx = idx;
        exp_q.push_back(e);
    endtask

    // A slot of len sclk periods: period 0 carries the transition, periods 1..DW the word
    task automatic model_slot(input bit ch, input int len, input logic [DW-1:0] w);
        int base = rise_cyc.size();
        if (!m_known) begin
            m_known = 1'b1;
            m_prev  = ch;
        end else if (ch != m_prev) begin
            m_prev = ch;
            if (m_phase == 0) begin
                m_phase = 1;
            end else begin
                if (m_phase == 2 && m_pend) push_exp(1'b0, '0, '0, base);
                m_phase = 2;
                if (!ch) m_left_ok = 1'b0;
                m_pend = (len - 1 >= 1) && (len - 1 < DW);
                if (len - 1 >= DW) begin
                    if (!ch) begin
                        m_hold    = w;
                        m_left_ok = 1'b1;
                    end else if (m_left_ok) begin
                        push_exp(1'b1, m_hold, w, base + DW);
                    end else begin
                        push_exp(1'b0, '0, '0, base + DW);
                    end
                end
            end
        end
    endtask

    task automatic drive_slot(input bit ch, input int len, input logic [DW-1:0] w, input bit fill_one, input int hp);
        for (int k = 0; k < len; k++) begin
            logic b;
            if (k >= 1 && k <= DW) b = w[DW-k];
            else                   b = fill_one ? 1'b1 : 1'($urandom);
            @(posedge clk_74a); #1;
            audio_sclk = 1'b0;
            audio_lrck = ch;
            audio_adc  = b;
            repeat (hp) @(posedge clk_74a);
            #1;
            audio_sclk = 1'b1;
            rise_cyc.push_back(cyc);
            repeat (hp - 1) @(posedge clk_74a);
        end
    endtask

    task automatic run_slot(input bit ch, input int len, input logic [DW-1:0] w, input bit fill_one, input int hp);
        model_slot(ch, len, w);
        drive_slot(ch, len, w, fill_one, hp);
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic do_reset(input bit toggle_sclk);
        repeat (6) @(posedge clk_74a);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        m_known   = 1'b0;
        m_phase   = 0;
        m_pend    = 1'b0;
        m_left_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_74a); #1;
            if (toggle_sclk) audio_sclk = 1'($urandom);
            audio_lrck = 1'($urandom);
            audio_adc  = 1'($urandom);
        end
        check_val("reset_outputs", 64'({left_sample, right_sample, sample_valid, word_drop}), 64'h0);
        audio_sclk = 1'b0;
        repeat (4) @(posedge clk_74a);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_74a);
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk_74a) begin
        if (sample_valid || word_drop) begin
            checks++;
            if (sample_valid) n_valid++;
            if (sample_valid && word_drop) begin
                errors++;
                $display("FAIL both_strobes: got valid=1 drop=1, required at most one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got valid=%0b drop=%0b, required none", sample_valid, word_drop);
            end else begin
                mon_e = exp_q.pop_front();
                if (sample_valid != mon_e.is_valid) begin
                    errors++;
                    $display("FAIL strobe_kind: got valid=%0b drop=%0b, required valid=%0b", sample_valid, word_drop, mon_e.is_valid);
                end else if (mon_e.is_valid) begin
                    checks++;
                    if (left_sample !== mon_e.l || right_sample !== mon_e.r) begin
                        errors++;
                        $display("FAIL pair_data: got %h/%h, required %h/%h", left_sample, right_sample, mon_e.l, mon_e.r);
                    end
                end
                checks++;
                if (mon_e.edge_idx >= rise_cyc.size()) begin
                    errors++;
                    $display("FAIL strobe_latency: strobe before its sclk edge %0d was driven", mon_e.edge_idx);
                end else if (cyc - rise_cyc[mon_e.edge_idx] != LAT) begin
                    errors++;
                    $display("FAIL strobe_latency: got %0d cycles, required %0d", cyc - rise_cyc[mon_e.edge_idx], LAT);
                end
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk_74a);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "timeout");
    end

    initial begin
        int v0;
        bit ch;
        int hp;

        // Reset with all inputs toggling, then idle with constant lrck
        do_reset(1'b1);
        run_slot(1'b0, 20, 16'($urandom), 1'b0, 12);
        check_val("idle_no_capture", 64'({left_sample, right_sample}), 64'h0);

        // Nominal frame after one lock transition, sclk = clk/24, 32-bit slots
        run_slot(1'b1, 32, 16'($urandom), 1'b0, 12);
        run_slot(1'b0, 32, 16'h1234, 1'b0, 12);
        run_slot(1'b1, 32, 16'hABCD, 1'b0, 12);
        repeat (8) @(posedge clk_74a);
        check_val("nominal_outputs", 64'({left_sample, right_sample}), 64'({16'h1234, 16'hABCD}));

        // Lock: all-ones data before the first edge, then extreme values, minimum slots
        do_reset(1'b0);
        run_slot(1'b0, 20, 16'hFFFF, 1'b1, 4);
        run_slot(1'b1, 20, 16'hFFFF, 1'b1, 4);
        run_slot(1'b0, 17, 16'h8000, 1'b0, 4);
        run_slot(1'b1, 17, 16'h7FFF, 1'b0, 4);
        repeat (8) @(posedge clk_74a);
        check_val("lock_outputs", 64'({left_sample, right_sample}), 64'({16'h8000, 16'h7FFF}));

        // Short left slot, then an orphan right word
        run_slot(1'b0, 8, 16'($urandom), 1'b0, 4);
        run_slot(1'b1, 20, 16'h5555, 1'b0, 4);
        repeat (8) @(posedge clk_74a);
        check_val("hold_after_drops", 64'({left_sample, right_sample}), 64'({16'h8000, 16'h7FFF}));

        // Reset during bit 5 of a right slot, then a fresh lock and frame
        run_slot(1'b0, 20, 16'h1111, 1'b0, 4);
        run_slot(1'b1, 6, 16'($urandom), 1'b0, 4);
        do_reset(1'b0);
        run_slot(1'b0, 10, 16'($urandom), 1'b0, 4);
        run_slot(1'b1, 20, 16'($urandom), 1'b0, 4);
        run_slot(1'b0, 20, 16'h0F0F, 1'b0, 4);
        run_slot(1'b1, 20, 16'hF0F0, 1'b0, 4);
        repeat (8) @(posedge clk_74a);
        check_val("post_reset_frame", 64'({left_sample, right_sample}), 64'({16'h0F0F, 16'hF0F0}));

        // Back-to-back frames with incrementing data and random rates / slot lengths
        v0 = n_valid;
        for (int i = 0; i < 100; i++) begin
            hp = $urandom_range(3, 5);
            run_slot(1'b0, $urandom_range(17, 20), 16'(16'h1000 + i), 1'b0, hp);
            run_slot(1'b1, $urandom_range(17, 20), 16'(16'h2000 + i), 1'b0, hp);
        end
        repeat (8) @(posedge clk_74a);
        checks++;
        if (!(n_valid - v0 == 99 || n_valid - v0 == 100)) begin
            errors++;
            $display("FAIL frame_count: got %0d strobes, required 99 or 100", n_valid - v0);
        end

        // Random slot lengths including short and single-period slots
        ch = 1'b0;
        for (int i = 0; i < 40; i++) begin
            run_slot(ch, $urandom_range(1, 24), 16'($urandom), 1'b0, $urandom_range(3, 5));
            ch = ~ch;
        end

        repeat (20) @(posedge clk_74a);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected: got %0d outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
